// File: rtl/eth_txctrl_pkg.sv
// Shared types and constants for the MAC transmit-control frame generator
// (802.3x PAUSE and 802.1Qbb PFC frames).
package eth_txctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_DATA,
    ST_WAITDONE
  } txctrl_state_e;

  localparam int TV_W        = 16;
  localparam int MAX_CLASSES = 8;

  localparam logic [47:0] CTRL_DA    = 48'h0180C2000001;
  localparam logic [15:0] CTRL_ETYPE = 16'h8808;
  localparam logic [15:0] OPC_PAUSE  = 16'h0001;
  localparam logic [15:0] OPC_PFC    = 16'h0101;

  localparam logic [5:0] LAST_PAUSE = 6'd17;
  localparam logic [5:0] LAST_PFC   = 6'd33;

endpackage

// File: rtl/eth_txctrl_bytemux.sv
// Combinational control-frame byte map: selects the byte at byteCnt_i from the
// fixed header fields and the latched per-frame shadow values.
module eth_txctrl_bytemux
  import eth_txctrl_pkg::*;
(
  input  logic [5:0]                  byteCnt_i,
  input  logic                        isPfc_i,
  input  logic [47:0]                 mac_i,
  input  logic [TV_W-1:0]             pauseTv_i,
  input  logic [MAX_CLASSES-1:0]      pfcEn_i,
  input  logic [MAX_CLASSES*TV_W-1:0] pfcTv_i,
  output logic [7:0]                  data_o
);

  logic [2:0] fieldSel;
  logic [3:0] pfcOff;

  always_comb begin
    fieldSel = 3'd0;
    pfcOff   = 4'(byteCnt_i - 6'd18);
    data_o   = 8'h00;
    if (byteCnt_i <= 6'd5) begin
      fieldSel = 3'(6'd5 - byteCnt_i);
      data_o   = CTRL_DA[{fieldSel, 3'b000} +: 8];
    end else if (byteCnt_i <= 6'd11) begin
      fieldSel = 3'(6'd11 - byteCnt_i);
      data_o   = mac_i[{fieldSel, 3'b000} +: 8];
    end else begin
      case (byteCnt_i)
        6'd12:   data_o = CTRL_ETYPE[15:8];
        6'd13:   data_o = CTRL_ETYPE[7:0];
        6'd14:   data_o = isPfc_i ? OPC_PFC[15:8] : OPC_PAUSE[15:8];
        6'd15:   data_o = isPfc_i ? OPC_PFC[7:0] : OPC_PAUSE[7:0];
        6'd16:   data_o = isPfc_i ? 8'h00 : pauseTv_i[15:8];
        6'd17:   data_o = isPfc_i ? pfcEn_i : pauseTv_i[7:0];
        // Class timers follow as hi/lo pairs: even offset is the high byte.
        default: if (isPfc_i && byteCnt_i <= LAST_PFC)
                   data_o = pfcTv_i[{pfcOff[3:1], ~pfcOff[0], 3'b000} +: 8];
      endcase
    end
  end

endmodule

// File: rtl/eth_txctrl_frmgen.sv
// Transmit-control frame generator: queues PAUSE/PFC requests, arbitrates them
// in at host-frame boundaries and feeds control bytes to the TX MAC.
module eth_txctrl_frmgen
  import eth_txctrl_pkg::*;
#(
  parameter int NUM_CLASSES   = 8,
  parameter int DLY_CRC_BYTES = 4
) (
  input  logic                        MTxClk,
  input  logic                        TxResetn,
  input  logic                        TPauseRq_i,
  input  logic                        TPfcRq_i,
  input  logic                        TxFlow_i,
  input  logic [TV_W-1:0]             TxPauseTV_i,
  input  logic [NUM_CLASSES-1:0]      TxPfcEn_i,
  input  logic [NUM_CLASSES*TV_W-1:0] TxPfcTV_i,
  input  logic [47:0]                 MAC_i,
  input  logic                        DlyCrcEn_i,
  input  logic                        TxUsedDataIn_i,
  input  logic                        TxUsedDataOut_i,
  input  logic                        TxStartFrmIn_i,
  input  logic                        TxDoneIn_i,
  input  logic                        TxAbortIn_i,
  output logic                        TxCtrlStartFrm_o,
  output logic                        TxCtrlEndFrm_o,
  output logic                        CtrlMux_o,
  output logic                        SendingCtrlFrm_o,
  output logic [7:0]                  ControlData_o,
  output logic                        WillSendControlFrame_o,
  output logic                        BlockTxDone_o,
  output logic                        CtrlFrmIsPfc_o
);

  localparam int STALL_W = (DLY_CRC_BYTES > 0) ? $clog2(DLY_CRC_BYTES + 1) : 1;

  txctrl_state_e state_q, state_d;
  logic [5:0]         byteCnt_q, byteCnt_d;
  logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
  logic pausePend_q, pausePend_d, pfcPend_q, pfcPend_d;
  logic ctrlMux_q, ctrlMux_d, sending_q, sending_d, blockDone_q, blockDone_d;
  logic latchShadow, clrPause, clrPfc, startFrm, endFrm, stallDone;
  logic [5:0] lastCnt;
  logic [7:0] muxData;

  logic                        isPfc_q, dlyCrc_q;
  logic [47:0]                 mac_q;
  logic [TV_W-1:0]             pauseTv_q;
  logic [MAX_CLASSES-1:0]      pfcEn_q, pfcEnPad;
  logic [MAX_CLASSES*TV_W-1:0] pfcTv_q, pfcTvPad;

  // Classes beyond NUM_CLASSES always transmit as zero.
  always_comb begin
    pfcEnPad = '0;
    pfcTvPad = '0;
    pfcEnPad[NUM_CLASSES-1:0]      = TxPfcEn_i;
    pfcTvPad[NUM_CLASSES*TV_W-1:0] = TxPfcTV_i;
  end

  always_comb begin
    state_d     = state_q;
    byteCnt_d   = byteCnt_q;
    stallCnt_d  = stallCnt_q;
    ctrlMux_d   = ctrlMux_q;
    sending_d   = sending_q;
    blockDone_d = blockDone_q;
    latchShadow = 1'b0;
    clrPause    = 1'b0;
    clrPfc      = 1'b0;
    startFrm    = 1'b0;
    endFrm      = 1'b0;
    stallDone   = !dlyCrc_q || (stallCnt_q == STALL_W'(DLY_CRC_BYTES));
    lastCnt     = isPfc_q ? LAST_PFC : LAST_PAUSE;
    if (TxStartFrmIn_i) blockDone_d = 1'b0;
    case (state_q)
      ST_IDLE: if ((pausePend_q || pfcPend_q) && !TxUsedDataOut_i) state_d = ST_ARB;
      ST_ARB: begin
        latchShadow = 1'b1;
        byteCnt_d   = '0;
        stallCnt_d  = '0;
        ctrlMux_d   = 1'b1;
        sending_d   = 1'b1;
        blockDone_d = 1'b1;
        state_d     = ST_START;
      end
      ST_START: begin
        startFrm = 1'b1;
        if (TxUsedDataIn_i) begin
          if (!stallDone) stallCnt_d = stallCnt_q + STALL_W'(1);
          else            byteCnt_d  = byteCnt_q + 6'd1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        endFrm = stallDone && (byteCnt_q == lastCnt);
        if (TxUsedDataIn_i) begin
          if (endFrm)          state_d    = ST_WAITDONE;
          else if (!stallDone) stallCnt_d = stallCnt_q + STALL_W'(1);
          else                 byteCnt_d  = byteCnt_q + 6'd1;
        end
      end
      ST_WAITDONE: if (TxDoneIn_i) begin
        ctrlMux_d = 1'b0;
        sending_d = 1'b0;
        clrPause  = !isPfc_q;
        clrPfc    = isPfc_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // An abort leaves the request pending so the frame is retried from byte 0.
    if (TxAbortIn_i && (state_q == ST_START || state_q == ST_DATA || state_q == ST_WAITDONE)) begin
      ctrlMux_d = 1'b0;
      sending_d = 1'b0;
      clrPause  = 1'b0;
      clrPfc    = 1'b0;
      state_d   = ST_IDLE;
    end
  end

  assign pausePend_d = (pausePend_q && !clrPause) || (TPauseRq_i && TxFlow_i);
  assign pfcPend_d   = (pfcPend_q && !clrPfc) || (TPfcRq_i && TxFlow_i);

  always_ff @(posedge MTxClk or negedge TxResetn) begin
    if (!TxResetn) begin
      state_q     <= ST_IDLE;
      byteCnt_q   <= '0;
      stallCnt_q  <= '0;
      pausePend_q <= 1'b0;
      pfcPend_q   <= 1'b0;
      ctrlMux_q   <= 1'b0;
      sending_q   <= 1'b0;
      blockDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byteCnt_q   <= byteCnt_d;
      stallCnt_q  <= stallCnt_d;
      pausePend_q <= pausePend_d;
      pfcPend_q   <= pfcPend_d;
      ctrlMux_q   <= ctrlMux_d;
      sending_q   <= sending_d;
      blockDone_q <= blockDone_d;
    end
  end

  // PAUSE wins a tie; the shadow holds frame fields stable while bytes drain.
  always_ff @(posedge MTxClk or negedge TxResetn) begin
    if (!TxResetn) begin
      isPfc_q   <= 1'b0;
      dlyCrc_q  <= 1'b0;
      mac_q     <= '0;
      pauseTv_q <= '0;
      pfcEn_q   <= '0;
      pfcTv_q   <= '0;
    end else if (latchShadow) begin
      isPfc_q   <= !pausePend_q;
      dlyCrc_q  <= DlyCrcEn_i;
      mac_q     <= MAC_i;
      pauseTv_q <= TxPauseTV_i;
      pfcEn_q   <= pfcEnPad;
      pfcTv_q   <= pfcTvPad;
    end
  end

  eth_txctrl_bytemux u_bytemux (
    .byteCnt_i (byteCnt_q),
    .isPfc_i   (isPfc_q),
    .mac_i     (mac_q),
    .pauseTv_i (pauseTv_q),
    .pfcEn_i   (pfcEn_q),
    .pfcTv_i   (pfcTv_q),
    .data_o    (muxData)
  );

  assign ControlData_o = ((state_q == ST_START || state_q == ST_DATA) && stallDone) ? muxData : 8'h00;
  assign TxCtrlStartFrm_o       = startFrm;
  assign TxCtrlEndFrm_o         = endFrm;
  assign CtrlMux_o              = ctrlMux_q;
  assign SendingCtrlFrm_o       = sending_q;
  assign WillSendControlFrame_o = pausePend_q || pfcPend_q;
  assign BlockTxDone_o          = blockDone_q;
  assign CtrlFrmIsPfc_o         = isPfc_q;

endmodule

// File: doc/eth_txctrl_frmgen.md
Name: eth_txctrl_frmgen

Overview:
- Parametrised successor to the MAC transmit-control path. Generates 802.3x PAUSE frames and 802.1Qbb priority flow control (PFC) frames with up to 8 priority classes.
- Arbitrates control-frame insertion against normal host frames at frame boundaries.
- Sits between eth_wishbone/host TX path and the TX MAC; drives byte-wide control data into the TX mux.

Parameters:
- NUM_CLASSES, 8, number of PFC priority classes (1..8); unused class-enable bits and timers transmit as 0.
- TV_W, 16, pause timer width; fixed at 16 for 802.3 compliance, kept as a named constant.
- DLY_CRC_BYTES, 4, bytes stalled at frame start when DlyCrcEn=1.

Ports:
- MTxClk  in  1  transmit clock
- TxResetn  in  1  reset
- TPauseRq  in  1  pulse: request PAUSE frame
- TPfcRq  in  1  pulse: request PFC frame
- TxFlow  in  1  flow control enabled; requests are ignored when 0
- TxPauseTV  in  16  PAUSE timer value, sampled at frame start
- TxPfcEn  in  NUM_CLASSES  PFC class-enable vector, sampled at frame start
- TxPfcTV  in  NUM_CLASSES*16  PFC timers; class i at [16i+15:16i]
- MAC  in  48  source address
- DlyCrcEn  in  1  delayed-CRC mode
- TxUsedDataIn  in  1  TX MAC consumed current byte
- TxUsedDataOut  in  1  host frame in progress
- TxStartFrmIn, TxDoneIn, TxAbortIn  in  1 each  TX MAC frame events
- TxCtrlStartFrm  out  1  control frame start
- TxCtrlEndFrm  out  1  last control byte
- CtrlMux  out  1  selects control data path
- SendingCtrlFrm  out  1  enables pad/CRC
- ControlData  out  8  current control byte
- WillSendControlFrame  out  1  any request pending
- BlockTxDone  out  1  suppress Done toward host
- CtrlFrmIsPfc  out  1  current/last frame type

Behaviour:
- Reset: TxResetn is asynchronous, active-low; clock is MTxClk. All outputs, pending flags, counters and the FSM clear to 0/IDLE.
- Pending flags: PausePend is set by TPauseRq&TxFlow; PfcPend is set by TPfcRq&TxFlow. Each clears only on TxDoneIn for a frame of its own type. A set and clear in the same cycle leaves the flag set (new request wins). WillSendControlFrame = PausePend|PfcPend.
- FSM states:
  - IDLE: when a request is pending and TxUsedDataOut=0, go to ARB.
  - ARB: takes 1 cycle. PAUSE wins a tie; the loser stays pending. Latch the type, TV/EnVec/timers and MAC into a shadow register. Assert CtrlMux; go to START.
  - START: TxCtrlStartFrm=1 until the first TxUsedDataIn, then go to DATA. SendingCtrlFrm is set on entry to START and BlockTxDone is set there too.
  - DATA: ByteCnt advances by 1 on each TxUsedDataIn. When DlyCrcEn=1, the first DLY_CRC_BYTES consumptions do not advance ByteCnt and ControlData=0x00 during them. TxCtrlEndFrm=1 while ByteCnt=LAST and the stall count is complete. TxUsedDataIn at LAST goes to WAITDONE.
  - WAITDONE: TxDoneIn clears CtrlMux and SendingCtrlFrm, clears the matching pending flag, and returns to IDLE.
- Byte map (ControlData, combinational from ByteCnt and the shadow register):
  - bytes 0-5: DA 01-80-C2-00-00-01
  - bytes 6-11: MAC[47:40] through MAC[7:0]
  - bytes 12-13: 0x88 0x08
  - opcode: 0x00 0x01 for PAUSE; 0x01 0x01 for PFC
  - PAUSE: TV hi/lo; LAST=17
  - PFC: 0x00, EnVec (8 bits, zero-extended), then 8 timers hi/lo for class 0..7; LAST=33
- BlockTxDone clears on the next TxStartFrmIn.
- TxAbortIn in START/DATA/WAITDONE: drop CtrlMux and SendingCtrlFrm, keep the pending flag (retry), return to IDLE.
- TxUsedDataIn in IDLE or ARB is ignored.
- A request that arrives while a frame is in progress only sets its flag; it is not retimed.

Decomposition:
- Package eth_txctrl_pkg: FSM state enum, DA/EtherType/opcode constants, LAST_PAUSE=17, LAST_PFC=33.
- One sub-module, eth_txctrl_bytemux: combinational byte map from ByteCnt, type and shadow register.

Test Plan:
- PAUSE, TxPauseTV=0x1234, MAC=0x0A0B0C0D0E0F, DlyCrcEn=0 -> bytes 01 80 C2 00 00 01 0A..0F 88 08 00 01 12 34; TxCtrlEndFrm on byte 17; pending clears on TxDoneIn.
- PFC, NUM_CLASSES=8, TxPfcEn=0x05, TV0=0xFFFF, TV2=0x0010 -> opcode 01 01, EnVec 00 05, 34 bytes total; CtrlFrmIsPfc=1.
- TPauseRq and TPfcRq in the same cycle -> PAUSE frame sent first, then PFC starts after TxDoneIn with WillSendControlFrame held high throughout.
- DlyCrcEn=1 -> 4 consumptions of 0x00 precede byte 0x01; total TxUsedDataIn count = 22 for PAUSE.
- TxAbortIn at byte 10 -> CtrlMux=0, FSM idle; frame restarts from byte 0 and completes.
- TxUsedDataOut=1 when the request arrives -> no TxCtrlStartFrm until TxUsedDataOut falls. Async reset mid-DATA -> all outputs 0 immediately.
